hps_mailbox_dispatcher: RTL
===========================

// Module: hps_mailbox_dispatcher
// PURPOSE
//  Parametrised HPS-to-fabric mailbox reader. Polls a shared SRAM mailbox, reads a packed entry list
//  and dispatches each entry as a pixel write to a one-hot column array (col_select/return_sig
//  handshake) or as a heat-source update for the grid generator. Writes a status word back, then
//  clears the ready flag. Sits between the HPS SRAM port and the column M10K array / generate_grid.
// PARAMETERS
//  N_COLS    64   number of columns; width of col_select and return_sig
//  ADDR_W    8    SRAM address width; mailbox depth is 2**ADDR_W words
//  PIX_W     8    pixel/heat value width (entry bits [PIX_W-1:0])
//  RD_LAT    2    SRAM read latency in cycles, counted from the address-valid edge to the data-sample edge
//  ACK_TMO   255  max cycles to wait for return_sig before dropping the entry
// PORTS
//  clock          in   1        system clock (CLOCK_50)
//  reset          in   1        asynchronous, active-low reset
//  sram_readdata  in   32       SRAM read data
//  sram_address   out  ADDR_W   SRAM address
//  sram_writedata out  32       SRAM write data
//  sram_write     out  1        SRAM write strobe, one cycle per word
//  col_select     out  N_COLS   one-hot column request
//  row_select     out  10       row for the current column write
//  pixel_color    out  PIX_W    value for the current column write
//  return_sig     in   N_COLS   per-column write acknowledge
//  heat_x, heat_y out  10       latest heat-source coordinates
//  heat_valid     out  1        one-cycle pulse when heat_x/heat_y update
//  done           out  1        one-cycle pulse after the mailbox is cleared
//  busy           out  1        high from list detection until done
// BEHAVIOUR
//  Mailbox layout:
//   - addr0: ready flag (nonzero = list present)
//   - addr1: entry count in [ADDR_W:0]; FPGA overwrites it with status when finished
//   - addr2..: entries {mode[31:30], x[29:20], y[17:8], val[PIX_W-1:0]}
//  Reset values: all outputs 0; sram_address 0; internal counters 0; state POLL.
//  Reset may assert in any state, e.g. mid-handshake; col_select drops immediately and no SRAM write issues.
//  Reads: address driven in *_REQ; data sampled exactly RD_LAT cycles later; sram_write low during reads.
//  State machine:
//   - POLL -> POLL_WAIT(RD_LAT) -> CHECK: flag==0 -> POLL, else busy<=1 -> CNT_REQ.
//   - CNT_REQ -> CNT_WAIT -> CNT_LATCH: count clamped to 2**ADDR_W-2; count==0 -> STATUS.
//   - ENT_REQ(addr=2+idx) -> ENT_WAIT -> DECODE, idx<=idx+1.
//   - DECODE mode 00 (pixel): x<N_COLS -> DISPATCH; x>=N_COLS -> err+1, NEXT.
//   - DECODE mode 01 (heat): heat_x/heat_y<=x/y, heat_valid pulse, NEXT.
//   - DECODE mode 11 (end marker): STATUS immediately; remaining entries are ignored.
//   - DECODE mode 10 (reserved): err+1, NEXT.
//   - DISPATCH: col_select<=1<<x, row_select<=y, pixel_color<=val, tmo<=0 -> ACK_WAIT.
//   - ACK_WAIT: return_sig[x]==1 -> col_select<=0, ok+1, NEXT. Other return_sig bits are ignored.
//   - ACK_WAIT timeout: tmo==ACK_TMO -> col_select<=0, err+1, NEXT.
//   - NEXT: idx==count -> STATUS, else ENT_REQ.
//   - STATUS: write addr1 <= {err[15:0], ok[15:0]} (both saturate at 16'hFFFF).
//   - CLEAR: write addr0 <= 0 the following cycle.
//   - DONE: done pulse, busy<=0, counters cleared -> POLL.
//  col_select is at most one-hot and is held until ack or timeout; pixel_color/row_select stay stable meanwhile.
//  Each dispatch holds col_select for at least one full cycle; an ack already high in the DISPATCH cycle is
//   accepted in the first ACK_WAIT cycle.
//  Widths: idx/count are ADDR_W+1 bits, so full-depth lists do not wrap; tmo is clog2(ACK_TMO+1) bits.
//  The block never reads addr0 between CHECK and CLEAR; HPS writes to the mailbox during busy are undefined.
// TESTING
//  - Flag 0 for 100 cycles -> only addr0 reads, col_select==0, busy==0, no sram_write.
//  - Flag 1, count 3 pixels (x=0,y=5,v=FF; x=63,y=479,v=01; x=10,y=0,v=80), ack 3 cycles later
//     -> three one-hot selects with matching row/colour, addr1<=0x00000003, addr0<=0, done pulse.
//  - Entry x=64 (N_COLS=64), then an entry never acked -> no select for x=64;
//     col_select drops after 255 cycles; status 0x00020000.
//  - Mode 01 entry x=70,y=12 followed by mode 11 then a pixel -> heat_valid pulse with 70/12;
//     trailing pixel never dispatched; status 0x00000000.
//  - count=0 and count=300 (ADDR_W=8) -> immediate STATUS; 254 entries read, idx never wraps.
//  - Assert reset mid-ACK_WAIT -> col_select, busy and sram_write all 0 asynchronously;
//     restart re-polls addr0 and reprocesses the list.

Source files
------------

// File: rtl/hps_mailbox_dispatcher.sv
// HPS mailbox reader: polls a shared SRAM list, dispatches pixel writes to the one-hot
// column array or heat-source updates, then writes a status word and clears the ready flag.
module hps_mailbox_dispatcher #(
    parameter int N_COLS  = 64,
    parameter int ADDR_W  = 8,
    parameter int PIX_W   = 8,
    parameter int RD_LAT  = 2,
    parameter int ACK_TMO = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       sram_readdata,
    output logic [ADDR_W-1:0] sram_address,
    output logic [31:0]       sram_writedata,
    output logic              sram_write,
    output logic [N_COLS-1:0] col_select,
    output logic [9:0]        row_select,
    output logic [PIX_W-1:0]  pixel_color,
    input  logic [N_COLS-1:0] return_sig,
    output logic [9:0]        heat_x,
    output logic [9:0]        heat_y,
    output logic              heat_valid,
    output logic              done,
    output logic              busy
);
    localparam int CNT_W = ADDR_W + 1;
    localparam int TMO_W = (ACK_TMO > 0) ? $clog2(ACK_TMO + 1) : 1;
    localparam int LAT_W = $clog2(RD_LAT + 1);
    localparam int COL_W = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'((1 << ADDR_W) - 2);
    localparam logic [10:0]      N_COLS_L = 11'(N_COLS);

    typedef enum logic [3:0] {
        S_POLL, S_RD_WAIT, S_CHECK, S_CNT_REQ, S_CNT_LATCH, S_ENT_REQ, S_DECODE,
        S_DISPATCH, S_ACK_WAIT, S_NEXT, S_STATUS, S_CLEAR, S_DONE
    } state_t;

    state_t           state;
    state_t           rd_tgt;
    logic [LAT_W-1:0] lat_cnt;
    logic [31:0]      rd_data;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] idx;
    logic [TMO_W-1:0] tmo;
    logic [15:0]      ok_cnt;
    logic [15:0]      err_cnt;

    logic [1:0]       ent_mode;
    logic [9:0]       ent_x;
    logic [9:0]       ent_y;
    logic [PIX_W-1:0] ent_val;
    logic [COL_W-1:0] ent_col;
    logic [CNT_W-1:0] raw_cnt;
    logic [CNT_W-1:0] ent_addr;

    // The last word read stays in rd_data until the next read, so the
    // entry fields remain valid through DISPATCH and ACK_WAIT.
    assign ent_mode = rd_data[31:30];
    assign ent_x    = rd_data[29:20];
    assign ent_y    = rd_data[17:8];
    assign ent_val  = rd_data[PIX_W-1:0];
    assign ent_col  = ent_x[COL_W-1:0];
    assign raw_cnt  = rd_data[CNT_W-1:0];
    assign ent_addr = idx + CNT_W'(2);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= S_POLL;
            rd_tgt         <= S_POLL;
            lat_cnt        <= '0;
            rd_data        <= '0;
            count          <= '0;
            idx            <= '0;
            tmo            <= '0;
            ok_cnt         <= '0;
            err_cnt        <= '0;
            sram_address   <= '0;
            sram_writedata <= '0;
            sram_write     <= 1'b0;
            col_select     <= '0;
            row_select     <= '0;
            pixel_color    <= '0;
            heat_x         <= '0;
            heat_y         <= '0;
            heat_valid     <= 1'b0;
            done           <= 1'b0;
            busy           <= 1'b0;
        end else begin
            heat_valid <= 1'b0;
            done       <= 1'b0;
            sram_write <= 1'b0;
            case (state)
                S_POLL: begin
                    sram_address <= '0;
                    lat_cnt      <= LAT_W'(1);
                    rd_tgt       <= S_CHECK;
                    state        <= S_RD_WAIT;
                end
                // Shared read wait: samples exactly RD_LAT edges after the address edge.
                S_RD_WAIT: begin
                    if (lat_cnt == LAT_W'(RD_LAT)) begin
                        rd_data <= sram_readdata;
                        state   <= rd_tgt;
                    end else begin
                        lat_cnt <= lat_cnt + LAT_W'(1);
                    end
                end
                S_CHECK: begin
                    if (rd_data == '0) begin
                        state <= S_POLL;
                    end else begin
                        busy  <= 1'b1;
                        state <= S_CNT_REQ;
                    end
                end
                S_CNT_REQ: begin
                    sram_address <= ADDR_W'(1);
                    lat_cnt      <= LAT_W'(1);
                    rd_tgt       <= S_CNT_LATCH;
                    state        <= S_RD_WAIT;
                end
                S_CNT_LATCH: begin
                    count <= (raw_cnt > MAX_CNT) ? MAX_CNT : raw_cnt;
                    state <= (raw_cnt == '0) ? S_STATUS : S_ENT_REQ;
                end
                S_ENT_REQ: begin
                    sram_address <= ent_addr[ADDR_W-1:0];
                    lat_cnt      <= LAT_W'(1);
                    rd_tgt       <= S_DECODE;
                    state        <= S_RD_WAIT;
                end
                S_DECODE: begin
                    idx <= idx + CNT_W'(1);
                    case (ent_mode)
                        2'b00: begin
                            if ({1'b0, ent_x} < N_COLS_L) begin
                                state <= S_DISPATCH;
                            end else begin
                                err_cnt <= sat_inc(err_cnt);
                                state   <= S_NEXT;
                            end
                        end
                        2'b01: begin
                            heat_x     <= ent_x;
                            heat_y     <= ent_y;
                            heat_valid <= 1'b1;
                            state      <= S_NEXT;
                        end
                        2'b11: state <= S_STATUS;
                        default: begin
                            err_cnt <= sat_inc(err_cnt);
                            state   <= S_NEXT;
                        end
                    endcase
                end
                S_DISPATCH: begin
                    col_select  <= N_COLS'(1) << ent_col;
                    row_select  <= ent_y;
                    pixel_color <= ent_val;
                    tmo         <= '0;
                    state       <= S_ACK_WAIT;
                end
                S_ACK_WAIT: begin
                    if (return_sig[ent_col]) begin
                        col_select <= '0;
                        ok_cnt     <= sat_inc(ok_cnt);
                        state      <= S_NEXT;
                    end else if (tmo == TMO_W'(ACK_TMO)) begin
                        col_select <= '0;
                        err_cnt    <= sat_inc(err_cnt);
                        state      <= S_NEXT;
                    end else begin
                        tmo <= tmo + TMO_W'(1);
                    end
                end
                S_NEXT: state <= (idx == count) ? S_STATUS : S_ENT_REQ;
                S_STATUS: begin
                    sram_address   <= ADDR_W'(1);
                    sram_writedata <= {err_cnt, ok_cnt};
                    sram_write     <= 1'b1;
                    state          <= S_CLEAR;
                end
                S_CLEAR: begin
                    sram_address   <= '0;
                    sram_writedata <= '0;
                    sram_write     <= 1'b1;
                    state          <= S_DONE;
                end
                S_DONE: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    idx     <= '0;
                    count   <= '0;
                    tmo     <= '0;
                    ok_cnt  <= '0;
                    err_cnt <= '0;
                    state   <= S_POLL;
                end
                default: state <= S_POLL;
            endcase
        end
    end
endmodule
